// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// controller states and operand-signedness decode.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MUL   = 2'd1,
      S_DIV   = 2'd2,
      S_FIXUP = 2'd3
   } state_e;

   function automatic logic op_is_signed(input logic [2:0] op_v);
      return (op_v == OP_MULT) || (op_v == OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_unit_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for
// divide. Operates on magnitudes only; sign handling lives in the top level.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             div_mode_i,
   input  logic [WIDTH-1:0] upper_i,
   input  logic [WIDTH-1:0] lower_i,
   input  logic [WIDTH-1:0] operand_i,
   output logic [WIDTH-1:0] upper_o,
   output logic [WIDTH-1:0] lower_o
);

   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   shifted_s;
   logic             borrow_s;

   // Remainder stays below the divisor, so the W-bit difference is exact when no borrow occurs.
   always_comb begin
      sum_s     = {1'b0, upper_i} + (lower_i[0] ? {1'b0, operand_i} : {(WIDTH+1){1'b0}});
      shifted_s = {upper_i, lower_i[WIDTH-1]};
      borrow_s  = (shifted_s < {1'b0, operand_i});
      if (div_mode_i) begin
         if (borrow_s) begin
            upper_o = shifted_s[WIDTH-1:0];
            lower_o = {lower_i[WIDTH-2:0], 1'b0};
         end else begin
            upper_o = shifted_s[WIDTH-1:0] - operand_i;
            lower_o = {lower_i[WIDTH-2:0], 1'b1};
         end
      end else begin
         upper_o = sum_s[WIDTH:1];
         lower_o = {sum_s[0], lower_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit. STEPS radix-2 steps are
// chained per clock; signed operations run on magnitudes and are corrected in FIXUP.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEPS = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int N     = WIDTH / STEPS;
   localparam int CNT_W = $clog2(N + 1);

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   upper_q, lower_q, operand_q;
   logic               neg_q, rneg_q, dz_q, is_mul_q;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               done_q;

   logic               sgn_s;
   logic               div_mode_s;
   logic [2*WIDTH-1:0] prod_s, prod_fix_s;
   logic [WIDTH-1:0]   hi_d, lo_d;
   logic [WIDTH-1:0]   up_s [0:STEPS];
   logic [WIDTH-1:0]   lw_s [0:STEPS];

   function automatic logic [WIDTH-1:0] mag(input logic sgn, input logic [WIDTH-1:0] x);
      if (sgn && x[WIDTH-1]) begin
         return '0 - x;
      end else begin
         return x;
      end
   endfunction

   assign sgn_s      = op_is_signed(op);
   assign div_mode_s = (state_q == S_DIV);
   assign up_s[0]    = upper_q;
   assign lw_s[0]    = lower_q;

   for (genvar g = 0; g < STEPS; g++) begin : g_step
      muldiv_step #(.WIDTH(WIDTH)) u_step (
         .div_mode_i (div_mode_s),
         .upper_i    (up_s[g]),
         .lower_i    (lw_s[g]),
         .operand_i  (operand_q),
         .upper_o    (up_s[g+1]),
         .lower_o    (lw_s[g+1])
      );
   end

   // Sign correction of the magnitude result; divide-by-zero forces an all-ones quotient.
   always_comb begin
      prod_s = {upper_q, lower_q};
      if (neg_q) begin
         prod_fix_s = '0 - prod_s;
      end else begin
         prod_fix_s = prod_s;
      end
      if (is_mul_q) begin
         hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
         lo_d = prod_fix_s[WIDTH-1:0];
      end else begin
         if (rneg_q) begin
            hi_d = '0 - upper_q;
         end else begin
            hi_d = upper_q;
         end
         if (dz_q) begin
            lo_d = '1;
         end else if (neg_q) begin
            lo_d = '0 - lower_q;
         end else begin
            lo_d = lower_q;
         end
      end
   end

   // Controller, iteration datapath and HI/LO registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         upper_q   <= '0;
         lower_q   <= '0;
         operand_q <= '0;
         neg_q     <= 1'b0;
         rneg_q    <= 1'b0;
         dz_q      <= 1'b0;
         is_mul_q  <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  case (op)
                     OP_MULT, OP_MULTU: begin
                        upper_q   <= '0;
                        lower_q   <= mag(sgn_s, b);
                        operand_q <= mag(sgn_s, a);
                        neg_q     <= sgn_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                        rneg_q    <= 1'b0;
                        dz_q      <= 1'b0;
                        is_mul_q  <= 1'b1;
                        cnt_q     <= CNT_W'(N);
                        state_q   <= S_MUL;
                     end
                     OP_DIV, OP_DIVU: begin
                        upper_q   <= '0;
                        lower_q   <= mag(sgn_s, a);
                        operand_q <= mag(sgn_s, b);
                        neg_q     <= sgn_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                        rneg_q    <= sgn_s & a[WIDTH-1];
                        dz_q      <= (b == '0);
                        is_mul_q  <= 1'b0;
                        cnt_q     <= CNT_W'(N);
                        state_q   <= S_DIV;
                     end
                     OP_MTHI: hi_q <= a;
                     OP_MTLO: lo_q <= a;
                     default: state_q <= S_IDLE;
                  endcase
               end
            end
            S_MUL, S_DIV: begin
               upper_q <= up_s[STEPS];
               lower_q <= lw_s[STEPS];
               cnt_q   <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= S_FIXUP;
               end
            end
            S_FIXUP: begin
               hi_q    <= hi_d;
               lo_q    <= lo_d;
               done_q  <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: a STEPS=1 and a STEPS=4 instance share one stimulus
// stream and are compared each cycle against an arithmetic reference model.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic [1:0]  busy_w, done_w;
   logic [31:0] hi_w [2];
   logic [31:0] lo_w [2];

   int          n_cmp = 0;
   int          n_bad = 0;
   logic        chk_en = 1'b0;

   logic [31:0] exp_hi [2] = '{32'd0, 32'd0};
   logic [31:0] exp_lo [2] = '{32'd0, 32'd0};
   logic        exp_done [2] = '{1'b0, 1'b0};
   int          pend [2] = '{0, 0};
   logic [63:0] res [2] = '{64'd0, 64'd0};

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(32), .STEPS(1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy_w[0]), .done(done_w[0]), .hi(hi_w[0]), .lo(lo_w[0])
   );

   muldiv_unit #(.WIDTH(32), .STEPS(4)) dut4 (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy_w[1]), .done(done_w[1]), .hi(hi_w[1]), .lo(lo_w[1])
   );

   function automatic int iters(input int d);
      return (d == 0) ? 32 : 8;
   endfunction

   // Result {hi,lo} from plain 64-bit arithmetic; longint division truncates toward zero.
   function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, q, r;
      logic [63:0] u;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         3'd0: begin
            q = sx * sy;
            return 64'(q);
         end
         3'd1: begin
            u = {32'd0, x} * {32'd0, y};
            return u;
         end
         3'd2: begin
            if (y == 32'd0) return {x, 32'hFFFF_FFFF};
            q = sx / sy;
            r = sx % sy;
            return {r[31:0], q[31:0]};
         end
         3'd3: begin
            if (y == 32'd0) return {x, 32'hFFFF_FFFF};
            return {x % y, x / y};
         end
         default: return 64'd0;
      endcase
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual %h required %h", nm, act, req);
      end
   endtask

   // Reference model: pending arithmetic result lands N+1 edges after acceptance.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         exp_done[d] <= 1'b0;
         if (reset) begin
            exp_hi[d] <= 32'd0;
            exp_lo[d] <= 32'd0;
            pend[d]   <= 0;
         end else if (pend[d] != 0) begin
            if (pend[d] == 1) begin
               exp_hi[d]   <= res[d][63:32];
               exp_lo[d]   <= res[d][31:0];
               exp_done[d] <= 1'b1;
            end
            pend[d] <= pend[d] - 1;
         end else if (start) begin
            if (op <= 3'd3) begin
               res[d]  <= ref_res(op, a, b);
               pend[d] <= iters(d) + 1;
            end else if (op == 3'd4) begin
               exp_hi[d] <= a;
            end else if (op == 3'd5) begin
               exp_lo[d] <= a;
            end
         end
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            check($sformatf("busy[%0d]", d), 64'(busy_w[d]), 64'(pend[d] != 0));
            check($sformatf("done[%0d]", d), 64'(done_w[d]), 64'(exp_done[d]));
            check($sformatf("hi[%0d]", d), 64'(hi_w[d]), 64'(exp_hi[d]));
            check($sformatf("lo[%0d]", d), 64'(lo_w[d]), 64'(exp_lo[d]));
         end
      end
   end

   task automatic run_arith(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                            input logic [31:0] ehi, input logic [31:0] elo, input string nm);
      int j1, j4;
      j1 = -1;
      j4 = -1;
      @(negedge clk);
      start = 1'b1; op = o; a = av; b = bv;
      @(negedge clk);
      start = 1'b0; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
      for (int j = 0; j <= 40; j++) begin
         if (done_w[0] && j1 < 0) j1 = j;
         if (done_w[1] && j4 < 0) j4 = j;
         @(negedge clk);
      end
      check({nm, " latency1"}, 64'(j1), 64'd33);
      check({nm, " latency4"}, 64'(j4), 64'd9);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("%s hi[%0d]", nm, d), 64'(hi_w[d]), 64'(ehi));
         check($sformatf("%s lo[%0d]", nm, d), 64'(lo_w[d]), 64'(elo));
      end
      check({nm, " model_hi"}, 64'(exp_hi[0]), 64'(ehi));
      check({nm, " model_lo"}, 64'(exp_lo[0]), 64'(elo));
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic saw_done;
      reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check("reset hi", 64'(hi_w[0]), 64'd0);
      check("reset lo", 64'(lo_w[0]), 64'd0);
      check("reset busy", 64'(busy_w), 64'd0);
      check("reset done", 64'(done_w), 64'd0);
      reset = 1'b0;

      run_arith(3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult");
      run_arith(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, "divu");
      run_arith(3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
      run_arith(3'd2, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, "div_zero");
      run_arith(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div_ovf");

      // Moves on consecutive cycles
      @(negedge clk);
      start = 1'b1; op = 3'd4; a = 32'h1234;
      @(negedge clk);
      op = 3'd5; a = 32'h5678;
      @(negedge clk);
      start = 1'b0;
      check("mthi hi", 64'(hi_w[0]), 64'h1234);
      check("mtlo lo", 64'(lo_w[0]), 64'h5678);
      check("move busy", 64'(busy_w), 64'd0);

      // Undefined opcode is ignored
      start = 1'b1; op = 3'd7; a = 32'hDEAD_BEEF;
      @(negedge clk);
      start = 1'b0;
      check("undef busy", 64'(busy_w), 64'd0);

      // Start while busy is ignored; reset aborts the operation
      @(negedge clk);
      start = 1'b1; op = 3'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort hi", 64'(hi_w[0]), 64'd0);
      check("abort lo", 64'(lo_w[0]), 64'd0);
      check("abort busy", 64'(busy_w[0]), 64'd0);
      saw_done = 1'b0;
      for (int j = 0; j < 40; j++) begin
         if (done_w[0]) saw_done = 1'b1;
         @(negedge clk);
      end
      check("abort no done", 64'(saw_done), 64'd0);

      // Randomized traffic with corner-biased operands and occasional resets
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 299) == 0);
         start = ($urandom_range(0, 3) == 0);
         op    = 3'($urandom_range(0, 7));
         a     = pick();
         b     = pick();
      end
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      repeat (40) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
